// File: rtl/if_stage_pkg.sv
// Shared definitions for the fetch stage and its decode-side consumers:
// reset vector, bus widths and branch bus field offsets.
package if_stage_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h1c000000;

  localparam int IF_ID_BUS_W   = 64;
  localparam int BR_BUS_W      = 34;
  localparam int BR_TAKEN_BIT  = 33;
  localparam int BR_CANCEL_BIT = 32;
  localparam int BR_TARGET_LSB = 0;

  typedef struct packed {
    logic        taken;
    logic        cancel;
    logic [31:0] target;
  } br_bus_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_chk.sv
// Simulation-only consistency checks for the fetch stage instruction source.
module if_stage_chk (
  input logic clk,
  input logic rst,
  input logic valid,
  input logic buf_valid,
  input logic rdata_fresh
);

  // A held instruction must come from either the buffer or fresh SRAM data
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(valid && !buf_valid && !rdata_fresh));
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, next-PC select, SRAM request and a
// one-entry buffer that keeps SRAM read data alive while decode stalls.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_allowin,
  input  logic [BR_BUS_W-1:0]    br_bus,
  output logic                   if_validout,
  output logic [IF_ID_BUS_W-1:0] if_to_id_bus,
  output logic                   inst_sram_en,
  output logic [3:0]             inst_sram_we,
  output logic [31:0]            inst_sram_addr,
  output logic [31:0]            inst_sram_wdata,
  input  logic [31:0]            inst_sram_rdata
);

  logic [31:0] pc_r;
  logic        valid_r;
  logic [31:0] buf_inst_r;
  logic        buf_valid_r;
  logic        rdata_fresh_r;

  logic        redir_s;
  logic [31:0] br_target_s;
  logic [31:0] seq_pc_s;
  logic [31:0] nextpc_s;
  logic        if_allowin_s;
  logic [31:0] inst_s;
  logic        unused_br_taken_s;

  // br_taken alone may fire on stale operands while decode is stalled; only cancel redirects
  assign redir_s           = br_bus[BR_CANCEL_BIT];
  assign br_target_s       = br_bus[BR_TARGET_LSB +: 32];
  assign unused_br_taken_s = br_bus[BR_TAKEN_BIT];

  // Pre-IF: next fetch address and IF acceptance
  always_comb begin
    seq_pc_s = pc_r + 32'd4;
    if (redir_s) begin
      nextpc_s = br_target_s;
    end else begin
      nextpc_s = seq_pc_s;
    end
    if_allowin_s = ~valid_r | id_allowin | redir_s;
  end

  // PC and valid register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r    <= RESET_PC - 32'd4;
      valid_r <= 1'b0;
    end else if (if_allowin_s) begin
      pc_r    <= nextpc_s;
      valid_r <= 1'b1;
    end else begin
      pc_r    <= pc_r;
      valid_r <= valid_r;
    end
  end

  // Instruction buffer: capture fresh SRAM data the first cycle decode refuses it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_inst_r    <= 32'h0000_0000;
      buf_valid_r   <= 1'b0;
      rdata_fresh_r <= 1'b0;
    end else if (if_allowin_s) begin
      buf_inst_r    <= buf_inst_r;
      buf_valid_r   <= 1'b0;
      rdata_fresh_r <= 1'b1;
    end else begin
      rdata_fresh_r <= 1'b0;
      if (valid_r && rdata_fresh_r && !id_allowin && !redir_s) begin
        buf_inst_r  <= inst_sram_rdata;
        buf_valid_r <= 1'b1;
      end else begin
        buf_inst_r  <= buf_inst_r;
        buf_valid_r <= buf_valid_r;
      end
    end
  end

  // Output select: buffered instruction wins over the SRAM port
  always_comb begin
    if (buf_valid_r) begin
      inst_s = buf_inst_r;
    end else begin
      inst_s = inst_sram_rdata;
    end
    if (valid_r) begin
      if_to_id_bus = {pc_r, inst_s};
    end else begin
      if_to_id_bus = {IF_ID_BUS_W{1'b0}};
    end
    if_validout     = valid_r;
    inst_sram_en    = if_allowin_s & ~rst;
    inst_sram_addr  = word_align(nextpc_s);
    inst_sram_we    = 4'b0000;
    inst_sram_wdata = 32'h0000_0000;
  end

  if_stage_chk u_chk (
    .clk         (clk),
    .rst         (rst),
    .valid       (valid_r),
    .buf_valid   (buf_valid_r),
    .rdata_fresh (rdata_fresh_r)
  );

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage LoongArch-subset pipeline, feeding the decode stage.
- Holds the PC and computes the next fetch address (pre-IF), issuing requests to a synchronous instruction SRAM with 1-cycle read latency.
- Delivers {pc, inst} to decode over the valid/allowin handshake.
- Consumes the 34-bit branch bus returned by decode.
- Contains a 1-entry instruction buffer so SRAM read data is not lost while decode stalls.

Parameters:
- RESET_PC, 32'h1c000000, address of the first instruction fetched after reset.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- id_allowin  in  1  decode can accept a new instruction this cycle.
- br_bus  in  34  {br_taken, br_taken_cancel, br_target[31:0]} from decode.
- if_validout  out  1  if_to_id_bus holds a valid instruction.
- if_to_id_bus  out  64  {pc[31:0], inst[31:0]}.
- inst_sram_en  out  1  read request this cycle.
- inst_sram_we  out  4  byte write enables; constant 4'b0000.
- inst_sram_addr  out  32  fetch address, word aligned.
- inst_sram_wdata  out  32  constant 0.
- inst_sram_rdata  in  32  read data; valid the cycle after an en-cycle.

Behaviour:
- Reset (async, rst=1):
  - pc_r=RESET_PC-4, valid=0, buf_valid=0, rdata_fresh=0.
  - Outputs: if_validout=0, if_to_id_bus=0, inst_sram_en=0.
- Redirect condition: redir = br_taken_cancel.
  - br_taken alone is ignored; it can assert while decode is stalled on a RAW hazard with stale rj.
- Pre-IF:
  - seq_pc = pc_r+4 (32-bit wrap).
  - nextpc = redir ? br_target : seq_pc.
  - inst_sram_addr = {nextpc[31:2], 2'b00}.
- Accept into IF: if_allowin = ~valid | id_allowin | redir.
  - inst_sram_en = if_allowin & ~rst.
- On posedge with if_allowin: pc_r<=nextpc, valid<=1, rdata_fresh<=1, buf_valid<=0.
  - Otherwise rdata_fresh<=0.
- Instruction select: inst = buf_valid ? buf_inst : inst_sram_rdata.
  - If valid & ~buf_valid & ~rdata_fresh occurs, that is an internal error; assert in simulation.
- Buffer capture: on posedge, if valid & rdata_fresh & ~id_allowin & ~redir, then buf_inst<=inst_sram_rdata and buf_valid<=1.
  - The buffer holds until handoff.
- Outputs: if_validout = valid; readygo is always 1. if_to_id_bus = {pc_r, inst}.
- Handoff: the instruction transfers on a cycle with if_validout & id_allowin; the new fetch loads that same edge, so sequential fetch runs back-to-back with no bubble.
- Redirect with decode accepting:
  - The current IF instruction is passed but is on the wrong path; decode drops it because its own cancel has priority.
  - IF loads br_target next cycle.
- Redirect with decode not accepting: IF itself discards its held instruction (buffer cleared) and loads br_target. Redirect is never lost, and the wrong-path instruction never reaches decode afterwards.
- Penalty: a taken branch costs exactly 1 bubble. The instruction at br_target reaches if_validout the cycle after the redirect pulse.
- Long stall: pc_r, buf_inst and if_to_id_bus stay stable for any number of stall cycles, regardless of inst_sram_rdata.
- Reset mid-operation: all state clears immediately; the first request after release is at RESET_PC, one cycle after rst falls.
- Misaligned br_target: the address is forced word aligned; pc_r keeps the full value.

Decomposition:
- Shared package: RESET_PC default, bus widths (IF_ID_BUS_W=64, BR_BUS_W=34), and br_bus field offsets, shared with decode.
- No sub-module required.
- The instruction buffer (buf_inst, buf_valid, rdata_fresh) may be a small helper if_inst_buf; inline is acceptable.

Test Plan:
- Reset then id_allowin=1 constant, SRAM returns addr as data:
  - inst_sram_addr sequence 0x1c000000, 0x1c000004, …
  - if_validout first high 1 cycle after the first en.
  - if_to_id_bus={0x1c000000, 0x1c000000}.
- Stall id_allowin=0 for 5 cycles while SRAM rdata is driven to garbage:
  - if_to_id_bus stays {0x1c000008, 0x1c000008} and en=0.
  - On release, the next PC handed over is 0x1c00000c with no skip or duplicate.
- br_bus={1, 1, 0x1c000100} pulse with id_allowin=1:
  - Next-cycle pc_r=0x1c000100 and inst_sram_addr that cycle=0x1c000100.
  - Exactly 1 bubble.
- Same pulse while id_allowin=0:
  - The held instruction is discarded and never handed over after the pulse.
  - The next valid pc is 0x1c000100.
- br_bus={1, 0, 0x1c000200} (taken, not cancel) for 3 cycles, stalled: no redirect; sequential PCs preserved.
- Assert rst for 1 cycle mid-stream with the buffer full:
  - Outputs clear asynchronously without a clock edge.
  - The fetch restarts at 0x1c000000.
